// File: rtl/vd_frame_pkg.sv
//==============================================================================
// Module  : vd_frame_pkg
// Brief   : Shared FSM state encoding and default parameters for the
//           decoder frame adapter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package vd_frame_pkg;

    localparam int DEF_FRAME_W     = 16;
    localparam int DEF_SYM_W       = 2;
    localparam int DEF_MSB_FIRST   = 1;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/vd_sym_serializer.sv
//==============================================================================
// Module  : vd_sym_serializer
// Brief   : Loads a coded frame and presents it one SYM_W-bit symbol at a
//           time, MSB-first or LSB-first.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vd_sym_serializer #(
    parameter int FRAME_W   = 16,
    parameter int SYM_W     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [FRAME_W-1:0] i_frame,
    output logic [SYM_W-1:0]   o_sym
);

    logic [FRAME_W-1:0] r_frame;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame <= '0;
        end else if (i_load) begin
            r_frame <= i_frame;
        end else if (i_shift) begin
            r_frame <= (MSB_FIRST != 0) ? (r_frame << SYM_W) : (r_frame >> SYM_W);
        end
    end

    // The current symbol always sits at the end the shift moves away from.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign o_sym = r_frame[FRAME_W-1 -: SYM_W];
        end else begin : g_lsb
            assign o_sym = r_frame[SYM_W-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vd_frame_adapter.sv
//==============================================================================
// Module  : vd_frame_adapter
// Brief   : Feeds a coded frame symbol-by-symbol to a decoder and collects
//           its decision bits into a decoded frame.
//           Optional decision timeout: define VD_FRAME_ADAPTER_TIMEOUT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vd_frame_adapter
    import vd_frame_pkg::*;
#(
    parameter int FRAME_W     = DEF_FRAME_W,
    parameter int SYM_W       = DEF_SYM_W,
    parameter int MSB_FIRST   = DEF_MSB_FIRST,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [FRAME_W-1:0]         i_data,
    output logic [SYM_W-1:0]           o_sym,
    output logic                       o_sym_valid,
    input  logic                       i_dec_bit,
    input  logic                       i_dec_valid,
    output logic [FRAME_W/SYM_W-1:0]   o_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);

    localparam int NUM_SYM   = FRAME_W / SYM_W;
    localparam int DEC_W     = NUM_SYM;
    localparam int SYM_CNT_W = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam int BIT_CNT_W = $clog2(DEC_W + 1);

    generate
        if ((FRAME_W % SYM_W) != 0) begin : g_bad_frame_w
            $error("vd_frame_adapter: FRAME_W must be a multiple of SYM_W");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("vd_frame_adapter: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    frame_state_t         r_state;
    logic [SYM_CNT_W-1:0] r_sym_cnt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [DEC_W-1:0]     r_collect;
    logic [DEC_W-1:0]     r_data;
    logic [SYM_W-1:0]     r_sym;
    logic                 r_sym_valid;
    logic                 r_busy;
    logic                 r_done;

    logic [SYM_W-1:0]     w_ser_sym;
    logic [DEC_W-1:0]     w_collect_next;
    logic                 w_accept;
    logic                 w_last_bit;
    logic                 w_bits_full;

`ifdef VD_FRAME_ADAPTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_error;
    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    vd_sym_serializer #(
        .FRAME_W   (FRAME_W),
        .SYM_W     (SYM_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  ((r_state == ST_IDLE) && i_start),
        .i_shift (r_state == ST_SEND),
        .i_frame (i_data),
        .o_sym   (w_ser_sym)
    );

    assign w_accept    = i_dec_valid && (r_bit_cnt != BIT_CNT_W'(DEC_W)) &&
                         ((r_state == ST_SEND) || (r_state == ST_WAIT));
    assign w_last_bit  = (r_bit_cnt == BIT_CNT_W'(DEC_W - 1));
    assign w_bits_full = (r_bit_cnt == BIT_CNT_W'(DEC_W)) || (w_accept && w_last_bit);

    // MSB-first shifts bits up so the first one ends in DEC_W-1 after DEC_W accepts.
    generate
        if (MSB_FIRST != 0) begin : g_cap_msb
            assign w_collect_next = (r_collect << 1) | DEC_W'(i_dec_bit);
        end else begin : g_cap_lsb
            assign w_collect_next = r_collect | (DEC_W'(i_dec_bit) << r_bit_cnt);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sym_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_collect   <= '0;
            r_data      <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef VD_FRAME_ADAPTER_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym       <= '0;

            if (w_accept) begin
                r_collect <= w_collect_next;
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_sym_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_collect <= '0;
`ifdef VD_FRAME_ADAPTER_TIMEOUT_EN
                        r_to_cnt  <= '0;
                        r_error   <= 1'b0;
`endif
                        r_busy    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_sym       <= w_ser_sym;
                    r_sym_valid <= 1'b1;
                    r_sym_cnt   <= r_sym_cnt + SYM_CNT_W'(1);
                    if (r_sym_cnt == SYM_CNT_W'(NUM_SYM - 1)) begin
                        if (w_bits_full) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_accept && w_last_bit) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
`ifdef VD_FRAME_ADAPTER_TIMEOUT_EN
                    else if (w_accept) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        // Abandon the frame; o_data keeps the previous result.
                        r_to_cnt <= '0;
                        r_error  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    r_data  <= r_collect;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sym       = r_sym;
    assign o_sym_valid = r_sym_valid;
    assign o_data      = r_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_vd_frame_adapter.sv
//==============================================================================
// Module  : tb_vd_frame_adapter
// Brief   : Scoreboard bench driving an MSB-first and an LSB-first adapter
//           with shared stimulus (honours VD_FRAME_ADAPTER_TIMEOUT_EN).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vd_frame_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data = '0;
    logic        dec_bit = 1'b0;
    logic        dec_valid = 1'b0;

    logic [1:0]  sym_m, sym_l;
    logic        sv_m, sv_l, busy_m, busy_l, done_m, done_l, err_m, err_l;
    logic [7:0]  dout_m, dout_l;

    int n_tests = 0;
    int n_fail  = 0;
    int done_m_cnt = 0;
    int done_l_cnt = 0;
    int exp_done = 0;
    logic [7:0] last_m = '0;
    logic [7:0] last_l = '0;

    logic [1:0] q_sym_m[$];
    logic [1:0] q_sym_l[$];
    logic [7:0] q_dat_m[$];
    logic [7:0] q_dat_l[$];

    vd_frame_adapter #(.FRAME_W(16), .SYM_W(2), .MSB_FIRST(1), .TIMEOUT_CYC(4)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_data(data),
        .o_sym(sym_m), .o_sym_valid(sv_m), .i_dec_bit(dec_bit), .i_dec_valid(dec_valid),
        .o_data(dout_m), .o_busy(busy_m), .o_done(done_m), .o_error(err_m)
    );

    vd_frame_adapter #(.FRAME_W(16), .SYM_W(2), .MSB_FIRST(0), .TIMEOUT_CYC(4)) dut_l (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_data(data),
        .o_sym(sym_l), .o_sym_valid(sv_l), .i_dec_bit(dec_bit), .i_dec_valid(dec_valid),
        .o_data(dout_l), .o_busy(busy_l), .o_done(done_l), .o_error(err_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Scoreboard side: compare every produced symbol and result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sv_m) begin
                if (q_sym_m.size() == 0) check("sym_m_extra", 32'(sv_m), 32'(0));
                else                     check("sym_m", 32'(sym_m), 32'(q_sym_m.pop_front()));
            end else begin
                check("sym_m_idle_zero", 32'(sym_m), 32'(0));
            end
            if (sv_l) begin
                if (q_sym_l.size() == 0) check("sym_l_extra", 32'(sv_l), 32'(0));
                else                     check("sym_l", 32'(sym_l), 32'(q_sym_l.pop_front()));
            end else begin
                check("sym_l_idle_zero", 32'(sym_l), 32'(0));
            end
            if (done_m) begin
                done_m_cnt++;
                if (q_dat_m.size() == 0) check("done_m_extra", 32'(done_m), 32'(0));
                else                     check("data_m", 32'(dout_m), 32'(q_dat_m.pop_front()));
            end
            if (done_l) begin
                done_l_cnt++;
                if (q_dat_l.size() == 0) check("done_l_extra", 32'(done_l), 32'(0));
                else                     check("data_l", 32'(dout_l), 32'(q_dat_l.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expected symbols; the i-th decision bit applied is seq[7-i].
    task automatic push_frame(input logic [15:0] f, input logic [7:0] seq, input bit with_data);
        for (int k = 0; k < 8; k++) begin
            q_sym_m.push_back(f[15-2*k -: 2]);
            q_sym_l.push_back(f[2*k +: 2]);
        end
        if (with_data) begin
            q_dat_m.push_back(seq);
            q_dat_l.push_back(rev8(seq));
            last_m = seq;
            last_l = rev8(seq);
            exp_done++;
        end
    endtask

    task automatic start_frame(input logic [15:0] f);
        data  = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        data  = '0;
    endtask

    task automatic send_bits(input logic [7:0] seq, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            dec_valid = 1'b1;
            dec_bit   = seq[7-i];
            tick();
        end
        dec_valid = 1'b0;
        dec_bit   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_m_cnt < exp_done && n < 40) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("done_m_cnt", 32'(done_m_cnt), 32'(exp_done));
        check("done_l_cnt", 32'(done_l_cnt), 32'(exp_done));
        check("sym_queue_empty", 32'(q_sym_m.size() + q_sym_l.size()), 32'(0));
        check("data_queue_empty", 32'(q_dat_m.size() + q_dat_l.size()), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m"}, {sym_m, sv_m, dout_m, busy_m, done_m, err_m}, 32'(0));
        check({tag, "_l"}, {sym_l, sv_l, dout_l, busy_l, done_l, err_l}, 32'(0));
    endtask

    initial begin
        #12;
        check_all_zero("reset_outputs");
        #10 rst_n = 1'b1;
        tick();

        // Frame decoded after all symbols, bits applied in WAIT.
        push_frame(16'hB4C1, 8'b1010_0101, 1'b1);
        start_frame(16'hB4C1);
        repeat (8) tick();
        check("busy_in_wait", 32'({busy_m, busy_l}), 32'(3));
        send_bits(8'b1010_0101, 0, 8);
        wait_done();

        // All decisions during SEND plus a surplus ninth bit.
        push_frame(16'h3C5A, 8'b1101_0000, 1'b1);
        start_frame(16'h3C5A);
        send_bits(8'b1101_0000, 0, 8);
        dec_valid = 1'b1;
        dec_bit   = 1'b1;
        tick();
        dec_valid = 1'b0;
        dec_bit   = 1'b0;
        check("done_after_last_sym", 32'({done_m, done_l}), 32'(3));
        wait_done();

        // A start request during SEND must be ignored.
        push_frame(16'h1234, 8'b0011_1100, 1'b1);
        start_frame(16'h1234);
        tick();
        tick();
        data  = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        data  = '0;
        repeat (5) tick();
        send_bits(8'b0011_1100, 0, 8);
        wait_done();

        // Reset while the fifth symbol is on the output.
        push_frame(16'hA5A5, 8'h00, 1'b0);
        start_frame(16'hA5A5);
        send_bits(8'b1110_0000, 0, 3);
        tick();
        tick();
        check("fifth_sym_valid", 32'({sv_m, sv_l}), 32'(3));
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        q_sym_m.delete();
        q_sym_l.delete();
        last_m = '0;
        last_l = '0;
        #3 rst_n = 1'b1;
        repeat (20) tick();
        check("no_done_after_reset", 32'(done_m_cnt), 32'(exp_done));
        check("data_after_reset", 32'({dout_m, dout_l}), 32'(0));

        push_frame(16'h6E93, 8'b1000_1110, 1'b1);
        start_frame(16'h6E93);
        repeat (8) tick();
        send_bits(8'b1000_1110, 0, 8);
        wait_done();

        // Three decisions then silence.
        push_frame(16'h0F0F, 8'b1100_1001, 1'b0);
        start_frame(16'h0F0F);
        repeat (8) tick();
        send_bits(8'b1100_1001, 0, 3);
`ifdef VD_FRAME_ADAPTER_TIMEOUT_EN
        begin
            int n = 0;
            while (!err_m && n < 30) begin
                tick();
                n++;
            end
            check("timeout_cycles", 32'(n), 32'(4));
        end
        check("timeout_err_l", 32'(err_l), 32'(1));
        check("timeout_busy", 32'({busy_m, busy_l}), 32'(0));
        check("timeout_data_m", 32'(dout_m), 32'(last_m));
        check("timeout_data_l", 32'(dout_l), 32'(last_l));
        repeat (5) tick();
        check("timeout_no_done", 32'(done_m_cnt + done_l_cnt), 32'(2 * exp_done));
        check("error_sticky", 32'({err_m, err_l}), 32'(3));
`else
        repeat (20) tick();
        check("wait_persists_busy", 32'({busy_m, busy_l}), 32'(3));
        check("error_tied_low", 32'({err_m, err_l}), 32'(0));
        q_dat_m.push_back(8'b1100_1001);
        q_dat_l.push_back(rev8(8'b1100_1001));
        last_m = 8'b1100_1001;
        last_l = rev8(8'b1100_1001);
        exp_done++;
        send_bits(8'b1100_1001, 3, 5);
        wait_done();
`endif

        // A fresh start clears any error and decodes normally.
        push_frame(16'h8001, 8'b0110_1110, 1'b1);
        start_frame(16'h8001);
        check("error_cleared", 32'({err_m, err_l}), 32'(0));
        repeat (8) tick();
        send_bits(8'b0110_1110, 0, 8);
        wait_done();
        check("final_data_m", 32'(dout_m), 32'(8'b0110_1110));
        check("final_data_l", 32'(dout_l), 32'(8'b0111_0110));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
